vec_activation: RTL

VEC_ACTIVATION -- requirements
Module: vec_activation

---
 rtl/vec_activation.sv | 110 +++++++++++
 1 files changed

// File: rtl/vec_activation.sv
// Applies a per-vector activation (identity/ReLU/leaky/clamp) to int8 chunks pulled from an upstream FIFO.
// Latency: 3 cycles from req_chunk_in to req_chunk_out, one chunk in flight at a time.
// Backpressure: no upstream read unless downstream is ready; EMIT holds its result while out_ready is low.
module vec_activation #(
    parameter int InVecLength = 8,
    parameter int WorkingRegs = 4,
    parameter int LeakShift   = 3,
    parameter int ClampMax    = 6
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         in_data_ready,
    input  logic [WorkingRegs-1:0][7:0]  in_data,
    input  logic                         out_ready,
    input  logic [1:0]                   act_mode,
    output logic                         req_chunk_in,
    output logic [WorkingRegs-1:0][7:0]  write_out_data,
    output logic                         req_chunk_out,
    output logic                         out_vector_valid
);

    localparam int ChunksPerVec = InVecLength / WorkingRegs;
    localparam int IdxW         = (ChunksPerVec > 1) ? $clog2(ChunksPerVec) : 1;

    if ((InVecLength % WorkingRegs) != 0 || InVecLength < WorkingRegs) begin : g_bad_len
        $error("vec_activation: InVecLength must be a non-zero multiple of WorkingRegs");
    end
    if (LeakShift < 0 || LeakShift > 7) begin : g_bad_shift
        $error("vec_activation: LeakShift must be in 0..7");
    end
    if (ClampMax < 0 || ClampMax > 127) begin : g_bad_clamp
        $error("vec_activation: ClampMax must be in 0..127");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        EMIT    = 2'd2
    } state_t;

    state_t            state;
    logic [IdxW-1:0]   chunk_idx;
    logic [1:0]        mode_q;

    function automatic logic [7:0] activate(input logic [1:0] mode, input logic [7:0] x);
        logic signed [7:0] sx;
        logic signed [7:0] lim;
        logic signed [7:0] leak;
        logic [7:0]        y;
        sx   = signed'(x);
        lim  = 8'(ClampMax);
        leak = sx >>> LeakShift;
        y    = x;
        case (mode)
            2'b01:   y = sx[7] ? 8'd0 : x;
            2'b10:   y = sx[7] ? leak : x;
            2'b11:   y = sx[7] ? 8'd0 : ((sx > lim) ? lim : x);
            default: y = x;
        endcase
        return y;
    endfunction

    // Upstream strobe must coincide with the IDLE decision, so it is decoded rather than registered.
    assign req_chunk_in = (state == IDLE) && in_data_ready && out_ready && !rst_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state            <= IDLE;
            chunk_idx        <= '0;
            mode_q           <= 2'b00;
            req_chunk_out    <= 1'b0;
            out_vector_valid <= 1'b0;
            write_out_data   <= '0;
        end else begin
            req_chunk_out    <= 1'b0;
            out_vector_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_data_ready && out_ready) begin
                        state <= CAPTURE;
                        // Mode is frozen for the whole vector at its first chunk.
                        if (chunk_idx == '0) begin
                            mode_q <= act_mode;
                        end
                    end
                end
                CAPTURE: begin
                    for (int k = 0; k < WorkingRegs; k++) begin
                        write_out_data[k] <= activate(mode_q, in_data[k]);
                    end
                    state <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        req_chunk_out <= 1'b1;
                        state         <= IDLE;
                        if (chunk_idx == IdxW'(ChunksPerVec - 1)) begin
                            out_vector_valid <= 1'b1;
                            chunk_idx        <= '0;
                        end else begin
                            chunk_idx <= chunk_idx + IdxW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
